pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//   Pipeline hazard controller for the 5-stage core. Sequences the IF/ID and ID/EX pipeline registers and the fetch PC.
//   - Stalls the front end on load-use hazards and data-memory wait.
//   - Flushes wrong-path instructions on EX-resolved jumps/branches.
//   - Holds a PC redirect until fetch accepts it, then drains in-flight fetches.
// PARAMETERS
//   FLUSH_CYC  2   cycles IF/ID stays flushed after a redirect is accepted (in-flight imem fetches); 0..7
// PORTS
//   clk              in   1   system clock, rising edge
//   rst_n            in   1   asynchronous, active-low reset
//   id_load_use_i    in   1   ID instr reads rd of load currently in EX
//   ex_jump_i        in   1   EX resolved a taken jump/branch this cycle
//   ex_jump_addr_i   in   32  target of that jump
//   mem_busy_i       in   1   data memory not ready; MEM stage must hold
//   if_ready_i       in   1   fetch unit accepted redirect this cycle
//   stall_pc_o       out  1   hold PC
//   stall_if_id_o    out  1   hold IF/ID register
//   stall_id_ex_o    out  1   hold ID/EX register
//   flush_if_id_o    out  1   load NOP/zero into IF/ID
//   flush_id_ex_o    out  1   load bubble into ID/EX
//   redirect_o       out  1   redirect request to fetch (registered)
//   redirect_pc_o    out  32  redirect target (registered)
//   stall_cnt_o      out  32  stall-cycle count (PIPE_CTRL_PERF_EN)
//   flush_cnt_o      out  32  redirect count (PIPE_CTRL_PERF_EN)
// BEHAVIOUR
//   Reset: state=RUN, redirect_o=0, redirect_pc_o=32'h0, drain counter=0, perf counters=0. Reset mid-operation abandons any pending redirect.
//   stall_*/flush_* are combinational from state and inputs (same-cycle effect). redirect_* are registered.
//   Priority in every state: mem_busy_i > ex_jump_i > id_load_use_i.
//   mem_busy_i=1 (any state):
//     - stall_pc/stall_if_id/stall_id_ex=1, no flush.
//     - State, counter and redirect_* are frozen.
//     - ex_jump_i is ignored; EX must hold it stable until mem_busy_i drops.
//   RUN:
//     - ex_jump_i: flush_if_id=flush_id_ex=1; redirect_pc<=ex_jump_addr_i, redirect<=1; ->REDIR.
//     - else id_load_use_i: stall_pc=stall_if_id=1, flush_id_ex=1 (one bubble); stay RUN.
//     - else all outputs 0.
//   REDIR:
//     - redirect_o=1, flush_if_id=1.
//     - if_ready_i: redirect<=0; ->DRAIN with cnt=FLUSH_CYC-1, or ->RUN if FLUSH_CYC==0.
//   DRAIN:
//     - flush_if_id=1, redirect_o=0; cnt decrements; cnt==0 -> RUN next cycle.
//     - id_load_use_i ignored (ID holds a flushed NOP).
//   ex_jump_i in REDIR/DRAIN is a protocol violation (ID/EX already bubbled): ignored; simulation assertion fires.
//   Redirect latency: jump cycle N -> redirect_o high at N+1, held until the if_ready_i cycle inclusive.
//   Counter widths: drain cnt 3 bits; perf counters 32-bit, wrap modulo 2^32.
// CONFIGURATION
//   PIPE_CTRL_PERF_EN defined:
//     - stall_cnt_o +1 every cycle stall_pc_o=1.
//     - flush_cnt_o +1 on every RUN->REDIR transition.
//   Not defined: counters not built; stall_cnt_o/flush_cnt_o tied to 32'h0 (ports kept).
// STRUCTURE
//   Shared pipe_pkg:
//     - state encodings RUN=2'd0, REDIR=2'd1, DRAIN=2'd2.
//     - NOP instruction constant 32'h00000013 used by IF/ID flush.
//   Sub-module pipe_ctrl_perf: the two counters, instantiated only under PIPE_CTRL_PERF_EN.
//   FSM and output decode stay in pipe_ctrl.
// TESTING
//   1. Reset while REDIR with redirect_pc=32'h80: rst_n low -> redirect_o=0, redirect_pc_o=0, all stalls/flushes 0 after release.
//   2. Load-use: id_load_use_i=1 for 1 cycle in RUN -> stall_pc=stall_if_id=flush_id_ex=1 that cycle only; state RUN.
//   3. Jump: ex_jump_i=1, addr=32'h0000_0100, if_ready_i low 2 cycles then high -> flushes in jump cycle; redirect_o=1 for 3 cycles, pc=0x100; then flush_if_id for 2 DRAIN cycles; RUN.
//   4. FLUSH_CYC=0: same jump with immediate if_ready_i -> REDIR 1 cycle, back to RUN, no DRAIN cycles.
//   5. Simultaneous mem_busy_i+ex_jump_i+id_load_use_i for 3 cycles -> only the three stalls set, no redirect; jump taken in first non-busy cycle.
//   6. PERF_EN: 5 load-use cycles + 2 jumps -> stall_cnt_o=5, flush_cnt_o=2; without macro both read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e   : controller FSM encodings (RUN / REDIR / DRAIN)
//   NOP_INSTR : instruction word loaded into IF/ID on flush (addi x0,x0,0)
package pipe_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned PERF_W = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REDIR = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Performance counters for the hazard controller.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   stall_pc    : PC held this cycle
//   redir_take  : RUN->REDIR transition this cycle
//   stall_cnt   : cycles with PC stalled (wraps modulo 2^32)
//   flush_cnt   : redirects taken (wraps modulo 2^32)
module pipe_ctrl_perf
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_pc,
    input  logic              redir_take,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    // Free-running event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_pc)   stall_cnt <= stall_cnt + PERF_W'(1);
            if (redir_take) flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller for the 5-stage core: stalls the front end on
// load-use hazards and data-memory wait, flushes wrong-path instructions on
// EX-resolved jumps, and holds a PC redirect until fetch accepts it, then
// drains FLUSH_CYC in-flight fetches.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   id_load_use_i     : load-use hazard in ID
//   ex_jump_i/_addr_i : taken jump/branch resolved in EX and its target
//   mem_busy_i        : data memory wait, freezes the whole controller
//   if_ready_i        : fetch accepted the redirect
//   stall_*_o/flush_*_o : combinational pipeline-register controls
//   redirect_o/_pc_o  : registered redirect request and target
//   stall_cnt_o/flush_cnt_o : perf counters (zero unless PIPE_CTRL_PERF_EN)
// Build option: PIPE_CTRL_PERF_EN enables the pipe_ctrl_perf counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_load_use_i,
    input  logic            ex_jump_i,
    input  logic [XLEN-1:0] ex_jump_addr_i,
    input  logic            mem_busy_i,
    input  logic            if_ready_i,
    output logic            stall_pc_o,
    output logic            stall_if_id_o,
    output logic            stall_id_ex_o,
    output logic            flush_if_id_o,
    output logic            flush_id_ex_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
);

    // Drain count loaded on redirect acceptance (unused when FLUSH_CYC==0)
    localparam logic [CNT_W-1:0] DRAIN_INIT =
        (FLUSH_CYC == 0) ? '0 : CNT_W'(FLUSH_CYC - 1);

    state_e           state;
    logic [CNT_W-1:0] drain_cnt;

    // Same-cycle stall/flush decode; mem_busy_i dominates everything
    always_comb begin
        stall_pc_o    = 1'b0;
        stall_if_id_o = 1'b0;
        stall_id_ex_o = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        if (mem_busy_i) begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            stall_id_ex_o = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ex_jump_i) begin
                        flush_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end else if (id_load_use_i) begin
                        stall_pc_o    = 1'b1;
                        stall_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end
                end
                ST_REDIR, ST_DRAIN: flush_if_id_o = 1'b1;
                default: ;
            endcase
        end
    end

    // FSM with registered redirect; frozen while memory is busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RUN;
            drain_cnt     <= '0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
        end else if (!mem_busy_i) begin
            case (state)
                ST_RUN: begin
                    if (ex_jump_i) begin
                        redirect_o    <= 1'b1;
                        redirect_pc_o <= ex_jump_addr_i;
                        state         <= ST_REDIR;
                    end
                end
                ST_REDIR: begin
                    if (if_ready_i) begin
                        redirect_o <= 1'b0;
                        drain_cnt  <= DRAIN_INIT;
                        state      <= (FLUSH_CYC == 0) ? ST_RUN : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) state <= ST_RUN;
                    else                 drain_cnt <= drain_cnt - CNT_W'(1);
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // A new jump while a redirect is outstanding means ID/EX was not bubbled
    assert property (@(posedge clk) disable iff (!rst_n)
        !(ex_jump_i && state != ST_RUN));

`ifdef PIPE_CTRL_PERF_EN
    logic redir_take;
    assign redir_take = !mem_busy_i && ex_jump_i && (state == ST_RUN);

    pipe_ctrl_perf u_perf (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_pc   (stall_pc_o),
        .redir_take (redir_take),
        .stall_cnt  (stall_cnt_o),
        .flush_cnt  (flush_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl (default FLUSH_CYC=2 instance
// plus a FLUSH_CYC=0 instance for the zero-drain case).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        lu, jmp, busy, rdy;
    logic [31:0] addr;
    logic        spc, sifid, sidex, fifid, fidex, redir;
    logic [31:0] rpc, scnt, fcnt;

    logic        b_lu, b_jmp, b_busy, b_rdy;
    logic [31:0] b_addr;
    logic        b_spc, b_sifid, b_sidex, b_fifid, b_fidex, b_redir;
    logic [31:0] b_rpc, b_scnt, b_fcnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_load_use_i(lu), .ex_jump_i(jmp), .ex_jump_addr_i(addr),
        .mem_busy_i(busy), .if_ready_i(rdy),
        .stall_pc_o(spc), .stall_if_id_o(sifid), .stall_id_ex_o(sidex),
        .flush_if_id_o(fifid), .flush_id_ex_o(fidex),
        .redirect_o(redir), .redirect_pc_o(rpc),
        .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
    );

    pipe_ctrl #(.FLUSH_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .id_load_use_i(b_lu), .ex_jump_i(b_jmp), .ex_jump_addr_i(b_addr),
        .mem_busy_i(b_busy), .if_ready_i(b_rdy),
        .stall_pc_o(b_spc), .stall_if_id_o(b_sifid), .stall_id_ex_o(b_sidex),
        .flush_if_id_o(b_fifid), .flush_id_ex_o(b_fidex),
        .redirect_o(b_redir), .redirect_pc_o(b_rpc),
        .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
    );

    // ctl bits: {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, redirect}
    typedef struct packed {
        logic        lu;
        logic        jmp;
        logic [31:0] addr;
        logic        busy;
        logic        rdy;
        logic [5:0]  ctl;
        logic [31:0] pc;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(logic l, logic j, logic [31:0] a, logic b,
                                logic r, logic [5:0] c, logic [31:0] p);
        vec_t v;
        v.lu = l; v.jmp = j; v.addr = a; v.busy = b; v.rdy = r;
        v.ctl = c; v.pc = p;
        return v;
    endfunction

    function automatic logic [5:0] ctl_a();
        return {spc, sifid, sidex, fifid, fidex, redir};
    endfunction

    function automatic logic [5:0] ctl_b();
        return {b_spc, b_sifid, b_sidex, b_fifid, b_fidex, b_redir};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic j, input logic [31:0] a,
                         input logic b, input logic r);
        lu = l; jmp = j; addr = a; busy = b; rdy = r;
    endtask

    logic [31:0] exp_s, exp_f;

    initial begin
        // Main sequence: reset idle, load-use, jump with slow fetch + drain
        // (load-use ignored in DRAIN), busy+jump+load-use, busy during DRAIN.
        vecs[0]  = mk(0, 0, 32'h0,   0, 0, 6'b000000, 32'h0);
        vecs[1]  = mk(1, 0, 32'h0,   0, 0, 6'b110010, 32'h0);
        vecs[2]  = mk(0, 0, 32'h0,   0, 0, 6'b000000, 32'h0);
        vecs[3]  = mk(0, 1, 32'h100, 0, 0, 6'b000110, 32'h0);
        vecs[4]  = mk(0, 0, 32'h0,   0, 0, 6'b000101, 32'h100);
        vecs[5]  = mk(0, 0, 32'h0,   0, 0, 6'b000101, 32'h100);
        vecs[6]  = mk(0, 0, 32'h0,   0, 1, 6'b000101, 32'h100);
        vecs[7]  = mk(1, 0, 32'h0,   0, 0, 6'b000100, 32'h100);
        vecs[8]  = mk(0, 0, 32'h0,   0, 0, 6'b000100, 32'h100);
        vecs[9]  = mk(0, 0, 32'h0,   0, 0, 6'b000000, 32'h100);
        vecs[10] = mk(1, 1, 32'h200, 1, 0, 6'b111000, 32'h100);
        vecs[11] = mk(1, 1, 32'h200, 1, 0, 6'b111000, 32'h100);
        vecs[12] = mk(1, 1, 32'h200, 1, 0, 6'b111000, 32'h100);
        vecs[13] = mk(1, 1, 32'h200, 0, 0, 6'b000110, 32'h100);
        vecs[14] = mk(0, 0, 32'h0,   0, 1, 6'b000101, 32'h200);
        vecs[15] = mk(0, 0, 32'h0,   1, 0, 6'b111000, 32'h200);
        vecs[16] = mk(0, 0, 32'h0,   0, 0, 6'b000100, 32'h200);
        vecs[17] = mk(0, 0, 32'h0,   0, 0, 6'b000100, 32'h200);
        vecs[18] = mk(0, 0, 32'h0,   0, 0, 6'b000000, 32'h200);

        drive(0, 0, 32'h0, 0, 0);
        b_lu = 0; b_jmp = 0; b_addr = 32'h0; b_busy = 0; b_rdy = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].lu, vecs[i].jmp, vecs[i].addr, vecs[i].busy, vecs[i].rdy);
            #1;
            check($sformatf("vec%0d ctl", i), 32'(ctl_a()), 32'(vecs[i].ctl));
            check($sformatf("vec%0d pc", i), rpc, vecs[i].pc);
            step();
        end

`ifdef PIPE_CTRL_PERF_EN
        exp_s = 32'd5; exp_f = 32'd2;
`else
        exp_s = 32'd0; exp_f = 32'd0;
`endif
        check("main stall_cnt", scnt, exp_s);
        check("main flush_cnt", fcnt, exp_f);

        // Reset while REDIR holding target 0x80
        drive(0, 1, 32'h80, 0, 0);
        step();
        drive(0, 0, 32'h0, 0, 0);
        #1;
        check("pre-reset redir ctl", 32'(ctl_a()), 32'(6'b000101));
        check("pre-reset redir pc", rpc, 32'h80);
        #1 rst_n = 1'b0;
        #1;
        check("in-reset ctl", 32'(ctl_a()), 32'h0);
        check("in-reset pc", rpc, 32'h0);
        check("in-reset stall_cnt", scnt, 32'h0);
        check("in-reset flush_cnt", fcnt, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        #1;
        check("post-reset ctl", 32'(ctl_a()), 32'h0);
        check("post-reset pc", rpc, 32'h0);

        // Five load-use cycles and two quickly-accepted jumps for the counters
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'h0, 0, 0);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 32'h40 * 32'(k + 1), 0, 0);
            step();
            drive(0, 0, 32'h0, 0, 1);
            step();
            drive(0, 0, 32'h0, 0, 0);
            step();
            step();
        end
        #1;
        check("perf final ctl", 32'(ctl_a()), 32'h0);
        check("perf stall_cnt", scnt, exp_s);
        check("perf flush_cnt", fcnt, exp_f);

        // FLUSH_CYC=0: REDIR for one cycle, then straight back to RUN
        b_jmp = 1; b_addr = 32'h100;
        #1;
        check("z jump ctl", 32'(ctl_b()), 32'(6'b000110));
        step();
        b_jmp = 0; b_addr = 32'h0; b_rdy = 1;
        #1;
        check("z redir ctl", 32'(ctl_b()), 32'(6'b000101));
        check("z redir pc", b_rpc, 32'h100);
        step();
        b_rdy = 0; b_lu = 1;
        #1;
        check("z run load-use ctl", 32'(ctl_b()), 32'(6'b110010));
        step();
        b_lu = 0;
        #1;
        check("z idle ctl", 32'(ctl_b()), 32'h0);
        check("z pc held", b_rpc, 32'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
